// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default PC width, saturating-counter
// encodings and the BTB entry record used by the branch predictor.
package mips_pkg;

    localparam int PC_W_DEFAULT = 32;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    // Tag and target are held at the default PC width and zero-extended on write.
    typedef struct packed {
        logic                    valid;
        logic [PC_W_DEFAULT-1:0] tag;
        logic [PC_W_DEFAULT-1:0] target;
    } btb_entry_t;

    function automatic int ctr_min();
        return int'(CTR_SNT);
    endfunction

    function automatic int ctr_max(input int w);
        return (w == 2) ? int'(CTR_ST) : (1 << w) - 1;
    endfunction

    function automatic int ctr_weak_taken(input int w);
        return (w == 2) ? int'(CTR_WT) : (1 << (w - 1));
    endfunction

    function automatic int ctr_weak_not_taken(input int w);
        return (w == 2) ? int'(CTR_WNT) : (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with force-to-max and parallel load,
// one instance per BTB entry.
module sat_counter
    import mips_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         force_max,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = W'(ctr_max(W));
    localparam logic [W-1:0] MIN_VAL = W'(ctr_min());
    localparam logic [W-1:0] RST_VAL = W'(ctr_weak_not_taken(W));

    // Jumps force the counter to strongly-taken even when the entry is newly allocated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RST_VAL;
        end else if (force_max) begin
            count <= MAX_VAL;
        end else if (load) begin
            count <= load_value;
        end else if (inc && count != MAX_VAL) begin
            count <= count + 1'b1;
        end else if (dec && count != MIN_VAL) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters for the 5-stage MIPS pipeline:
// zero-latency lookup from IF, training and misprediction detection from EX.
module branch_predictor
    import mips_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int MODE    = 1,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              predict_taken,
    output logic [PC_W-1:0]   predict_target,
    input  logic              ex_valid,
    input  logic              ex_is_jump,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_taken,
    input  logic [PC_W-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_pred_target,
    input  logic              flush_all,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [PERF_W-1:0] perf_updates,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_weak_taken(CTR_W));

    btb_entry_t       table_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;
    btb_entry_t       if_entry;
    logic             if_hit;
    logic             ex_hit;
    logic             upd_en;

    assign if_idx   = if_pc[IDX_W+1:2];
    assign if_tag   = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx   = ex_pc[IDX_W+1:2];
    assign ex_tag   = ex_pc[PC_W-1:IDX_W+2];
    assign if_entry = table_q[if_idx];

    assign if_hit = if_entry.valid && (if_entry.tag == PC_W_DEFAULT'(if_tag));
    assign ex_hit = table_q[ex_idx].valid && (table_q[ex_idx].tag == PC_W_DEFAULT'(ex_tag));

    // Counter MSB set is the same as being at or above weakly-taken.
    assign predict_taken  = (MODE == 1) && if_hit && (ctr_q[if_idx] >= CTR_ALLOC);
    assign predict_target = predict_taken ? PC_W'(if_entry.target) : if_pc + PC_W'(4);

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (ex_valid) begin
            mispredict  = (ex_pred_taken != ex_taken) ||
                          (ex_taken && (ex_pred_target != ex_target));
            redirect_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);
        end
    end

    // A flush in the same cycle wins and the training write is dropped.
    assign upd_en = ex_valid && (MODE == 1) && !flush_all;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic sel;
        assign sel = upd_en && (ex_idx == IDX_W'(i));

        sat_counter #(.W(CTR_W)) u_ctr (
            .clk        (clk),
            .reset      (reset),
            .inc        (sel && ex_hit && ex_taken),
            .dec        (sel && ex_hit && !ex_taken),
            .force_max  (sel && ex_taken && ex_is_jump),
            .load       (sel && !ex_hit && ex_taken),
            .load_value (CTR_ALLOC),
            .count      (ctr_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (upd_en && ex_taken) begin
            table_q[ex_idx] <= '{valid:  1'b1,
                                 tag:    PC_W_DEFAULT'(ex_tag),
                                 target: PC_W_DEFAULT'(ex_target)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_updates     <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (ex_valid && perf_updates != '1) begin
                perf_updates <= perf_updates + 1'b1;
            end
            if (mispredict && perf_mispredicts != '1) begin
                perf_mispredicts <= perf_mispredicts + 1'b1;
            end
        end
    end

endmodule
